// File: rtl/pce_pkg.sv
// Shared types and helpers for the pulse-code decoder.
package pce_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 2 ** CODE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Turn a binary code into a one-hot or thermometer line vector.
    function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code,
                                                input logic              therm);
        logic [OUT_W-1:0] pat;
        pat = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (therm) begin
                pat[k] = (CODE_W'(k) <= code);
            end else begin
                pat[k] = (CODE_W'(k) == code);
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/pce_req_slot.sv
// One-entry request buffer with valid/ready; ready is driven only from the
// valid register so it never depends combinationally on the requester.
module pce_req_slot #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_code,
    input  logic         in_therm,
    input  logic         pop,
    output logic         pend_valid,
    output logic [W-1:0] pend_code,
    output logic         pend_therm
);

    logic         valid_r;
    logic [W-1:0] code_r;
    logic         therm_r;

    // Capture a request when the slot is empty; release it when the consumer pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            code_r  <= '0;
            therm_r <= 1'b0;
        end else if (in_valid && !valid_r) begin
            valid_r <= 1'b1;
            code_r  <= in_code;
            therm_r <= in_therm;
        end else if (pop) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign in_ready   = !valid_r;
    assign pend_valid = valid_r;
    assign pend_code  = code_r;
    assign pend_therm = therm_r;

endmodule

// File: rtl/pulse_code_decoder.sv
// Decodes buffered binary codes into one-hot/thermometer pulses of fixed
// length, each followed by an optional all-zero gap.
module pulse_code_decoder
    import pce_pkg::*;
#(
    parameter int W         = CODE_W,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_code,
    input  logic            in_therm,
    output logic [2**W-1:0] out,
    output logic            busy,
    output logic            pulse_done
);

    localparam int MAX_PG = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int MAX_C  = (MAX_PG > 2) ? MAX_PG : 2;
    localparam int CW     = $clog2(MAX_C);
    localparam logic [CW-1:0] PULSE_RELOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_RELOAD   = CW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [2**W-1:0]   out_r, out_nxt_s;
    logic              busy_r;
    logic              done_r, done_nxt_s;
    logic              pop_s;
    logic              pend_valid_s;
    logic [W-1:0]      pend_code_s;
    logic              pend_therm_s;

    pce_req_slot #(.W(W)) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_therm   (in_therm),
        .pop        (pop_s),
        .pend_valid (pend_valid_s),
        .pend_code  (pend_code_s),
        .pend_therm (pend_therm_s)
    );

    // Next-state, counter and output pattern; a load always pops the slot.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        out_nxt_s   = '0;
        done_nxt_s  = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_valid_s) begin
                    state_nxt_s = DRIVE;
                    cnt_nxt_s   = PULSE_RELOAD;
                    out_nxt_s   = decode(pend_code_s, pend_therm_s);
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end
            end
            DRIVE: begin
                if (cnt_r == '0) begin
                    done_nxt_s = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_nxt_s = GAP;
                        cnt_nxt_s   = GAP_RELOAD;
                    end else if (pend_valid_s) begin
                        state_nxt_s = DRIVE;
                        cnt_nxt_s   = PULSE_RELOAD;
                        out_nxt_s   = decode(pend_code_s, pend_therm_s);
                        pop_s       = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = '0;
                    end
                end else begin
                    out_nxt_s = out_r;
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            GAP: begin
                if (cnt_r == '0) begin
                    if (pend_valid_s) begin
                        state_nxt_s = DRIVE;
                        cnt_nxt_s   = PULSE_RELOAD;
                        out_nxt_s   = decode(pend_code_s, pend_therm_s);
                        pop_s       = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = '0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter and all outputs registered; reset clears out immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            out_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            out_r   <= out_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= done_nxt_s;
        end
    end

    assign out        = out_r;
    assign busy       = busy_r;
    assign pulse_done = done_r;

endmodule
